// File: rtl/hazard_controller.sv
// Pipeline hazard unit: operand forwarding, load-use stall, branch flush,
// memory-wait freeze with a timeout that latches a sticky fault.
module hazard_controller #(
  parameter int REGISTER_ADDRESS_WIDTH = 5,
  parameter int MEM_TIMEOUT            = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1D,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2D,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1E,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2E,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdE,
  input  logic [1:0]                        ResultSrcE,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdM,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdW,
  input  logic                              RegWriteM,
  input  logic                              RegWriteW,
  input  logic                              PCSrcE,
  input  logic                              MemBusyM,
  output logic                              StallF,
  output logic                              StallD,
  output logic                              StallE,
  output logic                              StallM,
  output logic                              FlushD,
  output logic                              FlushE,
  output logic                              FlushW,
  output logic [1:0]                        ForwardAE,
  output logic [1:0]                        ForwardBE,
  output logic                              RedirectF,
  output logic                              MemFault,
  output logic [15:0]                       StallCount
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt, wait_cnt_nxt;
  logic          lw, freeze;
  logic [1:0]    fwd_a, fwd_b;

  always_comb begin
    fwd_a = 2'b00;
    if (RegWriteM && RdM != '0 && RdM == Rs1E)      fwd_a = 2'b10;
    else if (RegWriteW && RdW != '0 && RdW == Rs1E) fwd_a = 2'b01;
    fwd_b = 2'b00;
    if (RegWriteM && RdM != '0 && RdM == Rs2E)      fwd_b = 2'b10;
    else if (RegWriteW && RdW != '0 && RdW == Rs2E) fwd_b = 2'b01;
  end

  assign lw = (ResultSrcE == 2'b01) && (RdE != '0) && (RdE == Rs1D || RdE == Rs2D);

  // wait_cnt holds the busy cycles already seen in this stretch, so the
  // current busy cycle is number wait_cnt+1.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    freeze       = 1'b0;
    case (state)
      RUN: if (MemBusyM) begin
        freeze = 1'b1;
        if (MEM_TIMEOUT <= 1) state_nxt = FAULT;
        else begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = CW'(1);
        end
      end
      MEM_WAIT: if (MemBusyM) begin
        freeze = 1'b1;
        if (wait_cnt >= CW'(MEM_TIMEOUT - 1)) state_nxt = FAULT;
        else wait_cnt_nxt = wait_cnt + CW'(1);
      end else begin
        state_nxt = RUN;
      end
      FAULT:   freeze = 1'b1;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    RedirectF = 1'b0;
    ForwardAE = fwd_a;
    ForwardBE = fwd_b;
    MemFault  = (state == FAULT);
    if (rst) begin
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      FlushW    = 1'b1;
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      MemFault  = 1'b0;
    end else if (freeze) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      // a taken branch squashes D even when load-use is holding it
      StallF    = lw;
      StallD    = lw;
      FlushD    = PCSrcE;
      FlushE    = lw | PCSrcE;
      RedirectF = PCSrcE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      wait_cnt   <= '0;
      StallCount <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (StallF && StallCount != 16'hFFFF) StallCount <= StallCount + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed and random checks of hazard_controller against a run-length model.
module tb_hazard_controller;
  localparam int RAW = 5;
  localparam int TO  = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [RAW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]     ResultSrcE;
  logic           RegWriteM, RegWriteW, PCSrcE, MemBusyM;
  logic           StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0]     ForwardAE, ForwardBE;
  logic           RedirectF, MemFault;
  logic [15:0]    StallCount;

  hazard_controller #(.REGISTER_ADDRESS_WIDTH(RAW), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .ResultSrcE(ResultSrcE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
    .MemBusyM(MemBusyM), .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .StallM(StallM), .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .RedirectF(RedirectF),
    .MemFault(MemFault), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  // model: busy run length, sticky fault, stall count
  int run_len = 0;
  bit fault   = 0;
  int scount  = 0;
  bit sc_known = 0;
  int n_cmp = 0, n_err = 0;

  function automatic int fwd(input int rs);
    if (RegWriteM && RdM != 0 && int'(RdM) == rs) return 2;
    if (RegWriteW && RdW != 0 && int'(RdW) == rs) return 1;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input bit do_chk);
    bit frz, lu, sf;
    #2;
    frz = fault || MemBusyM;
    lu  = ResultSrcE == 2'b01 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    sf  = !rst && (frz || lu);
    if (do_chk) begin
      if (rst) begin
        chk("rst_stall", {StallF, StallD, StallE, StallM}, 16'h0);
        chk("rst_flush", {FlushD, FlushE, FlushW}, 16'h7);
        chk("rst_redir", 16'(RedirectF), 16'h0);
        chk("rst_fwd", {ForwardAE, ForwardBE}, 16'h0);
        chk("rst_fault", 16'(MemFault), 16'h0);
      end else begin
        chk("StallFD", {StallF, StallD}, sf ? 16'h3 : 16'h0);
        chk("StallEM", {StallE, StallM}, frz ? 16'h3 : 16'h0);
        chk("FlushD", 16'(FlushD), 16'(!frz && PCSrcE));
        chk("FlushE", 16'(FlushE), 16'(!frz && (lu || PCSrcE)));
        chk("FlushW", 16'(FlushW), 16'(frz));
        chk("RedirectF", 16'(RedirectF), 16'(!frz && PCSrcE));
        chk("ForwardAE", 16'(ForwardAE), 16'(fwd(int'(Rs1E))));
        chk("ForwardBE", 16'(ForwardBE), 16'(fwd(int'(Rs2E))));
        chk("MemFault", 16'(MemFault), 16'(fault));
      end
      if (sc_known) chk("StallCount", StallCount, 16'(scount));
    end
    @(posedge clk);
    if (rst) begin
      run_len = 0; fault = 0; scount = 0; sc_known = 1;
    end else begin
      if (!fault) begin
        run_len = MemBusyM ? run_len + 1 : 0;
        if (run_len >= TO) fault = 1;
      end
      if (sf && scount < 65535) scount++;
    end
    #1;
  endtask

  task automatic idle();
    rst = 0; Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE = 0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0; MemBusyM = 0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; MemBusyM = 1; PCSrcE = 1; step(1); step(1); rst = 0; MemBusyM = 0; PCSrcE = 0;
  endtask

  initial begin
    idle();
    do_reset();
    step(1);
    // forwarding priority
    RdM = 5; RdW = 5; Rs1E = 5; Rs2E = 5; RegWriteM = 1; RegWriteW = 1; step(1);
    RegWriteM = 0; step(1);
    RdM = 0; RdW = 0; step(1);
    idle();
    // load-use, then RdE=0 shows no stall
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7; step(1);
    RdE = 0; step(1);
    idle(); step(1);
    // memory wait of 3 cycles
    do_reset();
    MemBusyM = 1; repeat (3) step(1);
    MemBusyM = 0; step(1); step(1);
    // branch held through a wait
    PCSrcE = 1; MemBusyM = 1; repeat (2) step(1);
    MemBusyM = 0; step(1);
    idle(); step(1);
    // load-use together with branch
    ResultSrcE = 2'b01; RdE = 3; Rs1D = 3; PCSrcE = 1; step(1);
    idle(); step(1);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      Rs1D = 5'($urandom_range(0, 7)); Rs2D = 5'($urandom_range(0, 7));
      Rs1E = 5'($urandom_range(0, 7)); Rs2E = 5'($urandom_range(0, 7));
      RdE = 5'($urandom_range(0, 7)); RdM = 5'($urandom_range(0, 7));
      RdW = 5'($urandom_range(0, 7)); ResultSrcE = 2'($urandom_range(0, 3));
      RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      PCSrcE = ($urandom_range(0, 3) == 0);
      MemBusyM = ($urandom_range(0, 2) == 0);
      step(1);
    end
    // timeout and sticky fault, cleared only by reset
    do_reset();
    MemBusyM = 1; repeat (TO + 2) step(1);
    MemBusyM = 0; PCSrcE = 1; repeat (3) step(1);
    chk("fault_sticky", 16'(MemFault), 16'h1);
    do_reset();
    step(1);
    chk("fault_cleared", 16'(MemFault), 16'h0);
    // saturation: park in fault long enough to pass 16'hFFFF
    MemBusyM = 1; repeat (TO) step(1);
    MemBusyM = 0;
    repeat (65540) step(0);
    repeat (3) step(1);
    chk("stallcount_sat", StallCount, 16'hFFFF);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
